cmd_read: RTL and testbench
===========================

CMD_READ -- requirements
Module: cmd_read

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 64: maximum number of sample cycles to wait for a start bit.
REQ-002 SHALL have port sd_freq_clk_i  input  1  clock at SD frequency; cmd_i is sampled on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_i  input  1  SD CMD line, already resolved from the tri-state pad.
REQ-005 SHALL have port start_listening_i  input  1  one-cycle request to receive one response; accepted only in IDLE.
REQ-006 SHALL have port long_rsp_i  input  1  1 = 136-bit R2 response, 0 = 48-bit response; latched on acceptance.
REQ-007 SHALL have port check_crc_i  input  1  1 = CRC7 checked, 0 = CRC ignored (R3); latched on acceptance.
REQ-008 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-009 SHALL have port rsp_valid_o  output  1  one-cycle pulse when a response completes or times out.
REQ-010 SHALL have port rsp_index_o  output  6  received bits 45:40 (short) or 133:128 (long).
REQ-011 SHALL have port rsp_o  output  120  short: {88'b0, bits 39:8}; long: bits 127:8.
REQ-012 SHALL have port crc_err_o  output  1  CRC7 mismatch.
REQ-013 SHALL have port frame_err_o  output  1  transmission bit was not 0, or end bit was not 1.
REQ-014 SHALL have port timeout_err_o  output  1  no start bit arrived within TimeoutCycles.

Function
REQ-015 SHALL implement states IDLE, WAIT_START, RECEIVE, END_BIT and DONE.
REQ-016 IDLE: start_listening_i=1 SHALL latch long_rsp_i and check_crc_i, clear the timeout counter, and go to WAIT_START the next cycle.
REQ-017 WAIT_START: each sample with cmd_i=0 SHALL be taken as the start bit (bit 0), set the bit counter to 1, and go to RECEIVE.
REQ-018 WAIT_START: each sample with cmd_i=1 SHALL increment the timeout counter; after the TimeoutCycles-th such sample the block SHALL set timeout_err_o=1 and go to DONE.
REQ-019 Response length L SHALL be 48 for short and 136 for long; bits SHALL arrive MSB first, so sample n is bit L-1-n.
REQ-020 RECEIVE SHALL shift cmd_i into the response shift register and increment the bit counter each cycle; after sampling bit index L-2 it SHALL go to END_BIT.
REQ-021 END_BIT SHALL sample bit L-1 (the end bit), evaluate all errors, update outputs, and go to DONE.
REQ-022 DONE SHALL hold for exactly one cycle with rsp_valid_o=1, then go to IDLE; the minimum gap between accepted requests is therefore 1 cycle in IDLE.
REQ-023 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed serially.
REQ-024 CRC7 input range: short = bit indices 0..39; long = bit indices 8..127 (the start bit, transmission bit and reserved 111111 are excluded).
REQ-025 The received CRC SHALL be bit indices L-8..L-2; crc_err_o SHALL be 1 iff check_crc is latched 1 and the received CRC differs from the computed CRC.
REQ-026 frame_err_o SHALL be 1 iff bit index 1 was 1 or bit L-1 was 0.
REQ-027 On timeout, rsp_o and rsp_index_o SHALL keep their previous values, and crc_err_o and frame_err_o SHALL be 0.
REQ-028 rsp_o, rsp_index_o and all error flags SHALL hold their values from rsp_valid_o until the next rsp_valid_o.
REQ-029 start_listening_i in any state other than IDLE, including DONE, SHALL be ignored with no effect.
REQ-030 Changes of long_rsp_i or check_crc_i after acceptance SHALL have no effect on the response in progress.
REQ-031 A response arriving when the block is in IDLE SHALL be ignored.

Reset
REQ-032 Asserting rst_i at any time, including mid-response, SHALL force IDLE, clear all counters and the CRC state, and drive busy_o, rsp_valid_o and all error flags to 0, rsp_o to 0 and rsp_index_o to 0.
REQ-033 After rst_i deasserts, the first start_listening_i SHALL be accepted normally.

Verification
REQ-034 Short response: request with long=0, crc=1; 3 idle-high cycles, then an R1 frame with index 17, argument 0x00000900, correct CRC7 and end bit 1 -> one rsp_valid_o pulse, rsp_index_o=17, rsp_o=0x900, all errors 0, busy_o high for exactly 3+48+1+1 cycles counted from acceptance.
REQ-035 Long response: R2 frame with bits 127:8 = 0x0123456789ABCDEF0011223344556677 truncated to 120 bits, with correct CRC -> rsp_o equals that 120-bit field, crc_err_o=0.
REQ-036 CRC and frame errors: short frame with one argument bit flipped -> crc_err_o=1; the same frame with crc=0 -> crc_err_o=0; end bit 0 -> frame_err_o=1; transmission bit 1 -> frame_err_o=1.
REQ-037 Timeout: cmd_i held at 1 -> rsp_valid_o exactly at sample 64 after entering WAIT_START, with timeout_err_o=1; the previous rsp_o is unchanged.
REQ-038 Reset mid-response: assert rst_i at bit 20 -> immediately busy_o=0 and all outputs 0; a new request then receives a valid frame correctly.
REQ-039 Ignored requests: start_listening_i pulsed during RECEIVE and during DONE -> no second response is received, and the state sequence is unchanged.

Source files
------------

// File: rtl/cmd_read.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a 48- or
// 136-bit response MSB first, checks CRC7 and framing, and reports the result.
module cmd_read #(
  parameter int TimeoutCycles = 64
) (
  input  logic         sd_freq_clk_i,
  input  logic         rst_i,
  input  logic         cmd_i,
  input  logic         start_listening_i,
  input  logic         long_rsp_i,
  input  logic         check_crc_i,
  output logic         busy_o,
  output logic         rsp_valid_o,
  output logic [5:0]   rsp_index_o,
  output logic [119:0] rsp_o,
  output logic         crc_err_o,
  output logic         frame_err_o,
  output logic         timeout_err_o
);

  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    END_BIT,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_long;
  logic           r_chk;
  logic [TW-1:0]  r_to_cnt;
  logic [7:0]     r_bit_cnt;
  logic [134:0]   r_shift;
  logic [6:0]     r_crc;
  logic [5:0]     r_idx;
  logic [119:0]   r_rsp;
  logic           r_crc_err;
  logic           r_frame_err;
  logic           r_to_err;

  logic [7:0]     w_last_idx;
  logic           w_sample;
  logic           w_crc_en;
  logic           w_crc_fb;
  logic [6:0]     w_crc_next;
  logic           w_crc_err;
  logic           w_frame_err;

  assign w_last_idx = r_long ? 8'd134 : 8'd46;
  assign w_sample   = ((r_state == WAIT_START) && !cmd_i) || (r_state == RECEIVE);

  // Short CRC covers samples 0..39 (start bit included); long covers 8..127.
  assign w_crc_en = r_long ?
                    ((r_state == RECEIVE) && (r_bit_cnt >= 8'd8) && (r_bit_cnt <= 8'd127)) :
                    (w_sample && (r_bit_cnt <= 8'd39));
  assign w_crc_fb   = cmd_i ^ r_crc[6];
  assign w_crc_next = {r_crc[5:0], 1'b0} ^ (w_crc_fb ? 7'h09 : 7'h00);

  // At END_BIT the shift register holds samples 0..L-2 with the newest at bit 0.
  assign w_crc_err   = r_chk && (r_shift[6:0] != r_crc);
  assign w_frame_err = (r_long ? r_shift[133] : r_shift[45]) || !cmd_i;

  always_ff @(posedge sd_freq_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_listening_i) w_next = WAIT_START;
      end
      WAIT_START: begin
        if (!cmd_i)                   w_next = RECEIVE;
        else if (r_to_cnt == TO_LAST) w_next = DONE;
      end
      RECEIVE: begin
        if (r_bit_cnt == w_last_idx) w_next = END_BIT;
      end
      END_BIT: w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sd_freq_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_long      <= 1'b0;
      r_chk       <= 1'b0;
      r_to_cnt    <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_crc       <= '0;
      r_idx       <= '0;
      r_rsp       <= '0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_to_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_listening_i) begin
            r_long    <= long_rsp_i;
            r_chk     <= check_crc_i;
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_crc     <= '0;
          end
        end
        WAIT_START: begin
          if (!cmd_i) begin
            r_bit_cnt <= 8'd1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
            // Timeout keeps the previous response payload untouched.
            if (r_to_cnt == TO_LAST) begin
              r_to_err    <= 1'b1;
              r_crc_err   <= 1'b0;
              r_frame_err <= 1'b0;
            end
          end
        end
        RECEIVE: r_bit_cnt <= r_bit_cnt + 8'd1;
        END_BIT: begin
          r_idx       <= r_long ? r_shift[132:127] : r_shift[44:39];
          r_rsp       <= r_long ? r_shift[126:7] : {88'b0, r_shift[38:7]};
          r_crc_err   <= w_crc_err;
          r_frame_err <= w_frame_err;
          r_to_err    <= 1'b0;
        end
        default: ;
      endcase
      if (w_sample) r_shift <= {r_shift[133:0], cmd_i};
      if (w_crc_en) r_crc <= w_crc_next;
    end
  end

  assign busy_o        = (r_state != IDLE);
  assign rsp_valid_o   = (r_state == DONE);
  assign rsp_index_o   = r_idx;
  assign rsp_o         = r_rsp;
  assign crc_err_o     = r_crc_err;
  assign frame_err_o   = r_frame_err;
  assign timeout_err_o = r_to_err;

endmodule

// File: tb/tb_cmd_read.sv
// Scoreboard bench for cmd_read: directed SD response frames, expected results
// queued at stimulus time and compared by a monitor on each rsp_valid_o pulse.
module tb_cmd_read;

  logic         sd_freq_clk_i = 1'b0;
  logic         rst_i;
  logic         cmd_i;
  logic         start_listening_i;
  logic         long_rsp_i;
  logic         check_crc_i;
  logic         busy_o;
  logic         rsp_valid_o;
  logic [5:0]   rsp_index_o;
  logic [119:0] rsp_o;
  logic         crc_err_o;
  logic         frame_err_o;
  logic         timeout_err_o;

  cmd_read #(.TimeoutCycles(64)) dut (
    .sd_freq_clk_i     (sd_freq_clk_i),
    .rst_i             (rst_i),
    .cmd_i             (cmd_i),
    .start_listening_i (start_listening_i),
    .long_rsp_i        (long_rsp_i),
    .check_crc_i       (check_crc_i),
    .busy_o            (busy_o),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_index_o       (rsp_index_o),
    .rsp_o             (rsp_o),
    .crc_err_o         (crc_err_o),
    .frame_err_o       (frame_err_o),
    .timeout_err_o     (timeout_err_o)
  );

  always #5 sd_freq_clk_i = ~sd_freq_clk_i;

  typedef struct {
    logic [5:0]   idx;
    logic [119:0] rsp;
    logic         crc;
    logic         frm;
    logic         tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [5:0] idx, input logic [119:0] rsp,
                          input logic crc, input logic frm, input logic tmo);
    exp_t e;
    e.idx = idx; e.rsp = rsp; e.crc = crc; e.frm = frm; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] f, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = f[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] mk_short(input logic trans, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic endb);
    logic [135:0] f;
    f        = '0;
    f[47]    = 1'b0;
    f[46]    = trans;
    f[45:40] = idx;
    f[39:8]  = arg;
    f[7:1]   = crc7(f, 47, 8);
    f[0]     = endb;
    return f;
  endfunction

  function automatic logic [135:0] mk_long(input logic [119:0] data);
    logic [135:0] f;
    f          = '0;
    f[133:128] = 6'h3F;
    f[127:8]   = data;
    f[7:1]     = crc7(f, 127, 8);
    f[0]       = 1'b1;
    return f;
  endfunction

  // Pulses start for the acceptance edge, then scrambles the mode inputs so a
  // design that fails to latch them is caught, then idles the line high.
  task automatic do_req(input logic lng, input logic chk, input int idle_n);
    long_rsp_i        = lng;
    check_crc_i       = chk;
    start_listening_i = 1'b1;
    @(posedge sd_freq_clk_i); #1;
    start_listening_i = 1'b0;
    long_rsp_i        = ~lng;
    check_crc_i       = ~chk;
    cmd_i             = 1'b1;
    repeat (idle_n) begin @(posedge sd_freq_clk_i); #1; end
  endtask

  task automatic send_frame(input logic [135:0] f, input int len, input int pulse_at, input int nbits);
    for (int n = 0; n < nbits; n++) begin
      cmd_i = f[len-1-n];
      if (n == pulse_at) start_listening_i = 1'b1;
      @(posedge sd_freq_clk_i); #1;
      start_listening_i = 1'b0;
    end
    cmd_i = 1'b1;
  endtask

  always @(negedge sd_freq_clk_i) begin
    if (rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid_o=1 expected no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_index", 120'(rsp_index_o), 120'(e.idx));
        check("rsp_data", rsp_o, e.rsp);
        check("crc_err", 120'(crc_err_o), 120'(e.crc));
        check("frame_err", 120'(frame_err_o), 120'(e.frm));
        check("timeout_err", 120'(timeout_err_o), 120'(e.tmo));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [135:0] f;
    logic [127:0] d128;
    logic [119:0] d120;
    int           bc;
    int           n;

    rst_i = 1'b1; cmd_i = 1'b1; start_listening_i = 1'b0;
    long_rsp_i = 1'b0; check_crc_i = 1'b0;
    repeat (3) @(posedge sd_freq_clk_i);
    #1;
    check("rst_busy", 120'(busy_o), 120'(0));
    check("rst_valid", 120'(rsp_valid_o), 120'(0));
    check("rst_index", 120'(rsp_index_o), 120'(0));
    check("rst_rsp", rsp_o, 120'(0));
    check("rst_errs", 120'({crc_err_o, frame_err_o, timeout_err_o}), 120'(0));
    rst_i = 1'b0;
    @(posedge sd_freq_clk_i); #1;

    // R1, index 17, argument 0x900; busy measured from the acceptance cycle.
    f = mk_short(1'b0, 6'd17, 32'h0000_0900, 1'b1);
    push_exp(6'd17, 120'h900, 1'b0, 1'b0, 1'b0);
    bc = 0;
    fork
      begin
        do_req(1'b0, 1'b1, 3);
        send_frame(f, 48, -1, 48);
      end
      begin
        bc = 1;
        for (int k = 0; k < 200; k++) begin
          @(posedge sd_freq_clk_i); #2;
          if (!busy_o) break;
          bc++;
        end
      end
    join
    check("busy_len", 120'(bc), 120'(3 + 48 + 1 + 1));
    repeat (2) begin @(posedge sd_freq_clk_i); #1; end

    // R2 long response.
    d128 = 128'h0123456789ABCDEF0011223344556677;
    d120 = d128[119:0];
    f = mk_long(d120);
    push_exp(6'h3F, d120, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 1'b1, 2);
    send_frame(f, 136, -1, 136);
    repeat (3) begin @(posedge sd_freq_clk_i); #1; end

    // One argument bit flipped, CRC checked then ignored.
    f = mk_short(1'b0, 6'd17, 32'h0000_0900, 1'b1);
    f[8] = ~f[8];
    push_exp(6'd17, 120'h901, 1'b1, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 1);
    send_frame(f, 48, -1, 48);
    repeat (2) begin @(posedge sd_freq_clk_i); #1; end
    push_exp(6'd17, 120'h901, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 1);
    send_frame(f, 48, -1, 48);
    repeat (2) begin @(posedge sd_freq_clk_i); #1; end

    // End bit 0, then transmission bit 1 (CRC consistent with the bits sent).
    f = mk_short(1'b0, 6'd17, 32'h0000_0900, 1'b0);
    push_exp(6'd17, 120'h900, 1'b0, 1'b1, 1'b0);
    do_req(1'b0, 1'b1, 0);
    send_frame(f, 48, -1, 48);
    repeat (2) begin @(posedge sd_freq_clk_i); #1; end
    f = mk_short(1'b1, 6'd5, 32'hCAFE_0001, 1'b1);
    push_exp(6'd5, 120'hCAFE_0001, 1'b0, 1'b1, 1'b0);
    do_req(1'b0, 1'b1, 4);
    send_frame(f, 48, -1, 48);
    repeat (2) begin @(posedge sd_freq_clk_i); #1; end

    // Timeout: previous payload kept, pulse at the 64th sample.
    push_exp(6'd5, 120'hCAFE_0001, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 1'b1, 0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge sd_freq_clk_i); #1;
      n++;
      if (rsp_valid_o) break;
    end
    check("timeout_sample", 120'(n), 120'(64));
    repeat (2) begin @(posedge sd_freq_clk_i); #1; end

    // Requests during RECEIVE and DONE must be ignored.
    f = mk_short(1'b0, 6'd42, 32'h1234_5678, 1'b1);
    push_exp(6'd42, 120'h1234_5678, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 1);
    send_frame(f, 48, 10, 48);
    start_listening_i = 1'b1;
    @(posedge sd_freq_clk_i); #1;
    start_listening_i = 1'b0;
    repeat (80) begin @(posedge sd_freq_clk_i); #1; end
    check("no_rearm_busy", 120'(busy_o), 120'(0));

    // A frame arriving while idle is ignored.
    f = mk_short(1'b0, 6'd9, 32'h0000_0001, 1'b1);
    send_frame(f, 48, -1, 48);
    repeat (2) begin @(posedge sd_freq_clk_i); #1; end
    check("idle_frame_busy", 120'(busy_o), 120'(0));

    // Reset at bit 20 of a response, then a clean request.
    f = mk_short(1'b0, 6'd3, 32'hDEAD_BEEF, 1'b1);
    do_req(1'b0, 1'b1, 2);
    send_frame(f, 48, -1, 20);
    rst_i = 1'b1;
    #1;
    check("mid_rst_busy", 120'(busy_o), 120'(0));
    check("mid_rst_valid", 120'(rsp_valid_o), 120'(0));
    check("mid_rst_index", 120'(rsp_index_o), 120'(0));
    check("mid_rst_rsp", rsp_o, 120'(0));
    check("mid_rst_errs", 120'({crc_err_o, frame_err_o, timeout_err_o}), 120'(0));
    @(posedge sd_freq_clk_i); #1;
    rst_i = 1'b0;
    @(posedge sd_freq_clk_i); #1;
    push_exp(6'd3, 120'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 1);
    send_frame(f, 48, -1, 48);
    repeat (5) begin @(posedge sd_freq_clk_i); #1; end

    check("queue_empty", 120'(exp_q.size()), 120'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
